// File: rtl/op_req_sequencer.sv
// op_req_sequencer
//
// Receiving end of the operand-request channel from the instruction launcher.
// Buffers up to two operand requests and expands the head request into one
// stream of VRF block reads per operand queue (queue 0 reads vs1, queue 1
// reads vs2). Each queue advances one block per granted cycle. When a queue
// completes, a registered done pulse returns that queue's source register to
// the scoreboard so the read hazard can be released.
//
// Ports
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   op_req_valid_i    request valid from the launcher
//   op_req_ready_o    request FIFO has room
//   op_req_i          packed request, MSB to LSB: {vs1, vs2, queue_req, acc_cnt}
//   rd_req_valid_o    per-queue VRF read request valid
//   rd_req_addr_o     per-queue VRF block address
//   rd_req_ready_i    per-queue grant from the VRF bank arbiter
//   op_access_done_o  per-queue one-cycle completion pulse
//   op_access_vs_o    per-queue source register, valid with the done pulse
module op_req_sequencer #(
    parameter int unsigned NrOpQueue     = 2,
    parameter int unsigned VRegWidth     = 5,
    parameter int unsigned BlocksPerVReg = 4,
    parameter int unsigned AccCntWidth   = 8,
    parameter int unsigned AddrWidth     = VRegWidth + $clog2(BlocksPerVReg)
) (
    input  logic                                      clk_i,
    input  logic                                      rst_ni,
    input  logic                                      op_req_valid_i,
    output logic                                      op_req_ready_o,
    input  logic [2*VRegWidth+NrOpQueue+AccCntWidth-1:0] op_req_i,
    output logic [NrOpQueue-1:0]                      rd_req_valid_o,
    output logic [NrOpQueue-1:0][AddrWidth-1:0]       rd_req_addr_o,
    input  logic [NrOpQueue-1:0]                      rd_req_ready_i,
    output logic [NrOpQueue-1:0]                      op_access_done_o,
    output logic [NrOpQueue-1:0][VRegWidth-1:0]       op_access_vs_o
);

    localparam int unsigned LogBlocks = $clog2(BlocksPerVReg);
    localparam logic [AccCntWidth-1:0] CntOne = AccCntWidth'(1);

    typedef struct packed {
        logic [VRegWidth-1:0]   vs1;
        logic [VRegWidth-1:0]   vs2;
        logic [NrOpQueue-1:0]   queue_req;
        logic [AccCntWidth-1:0] acc_cnt;
    } op_req_t;

    // Two-entry request FIFO; payload storage carries no reset.
    op_req_t fifo_q [2];
    logic    rd_ptr_q;
    logic    wr_ptr_q;
    logic [1:0] count_q;

    // Per-queue progress through the head entry.
    logic [NrOpQueue-1:0][AccCntWidth-1:0] cnt_q;
    logic [NrOpQueue-1:0]                  fin_q;

    op_req_t head;
    logic    not_empty;
    logic    push;
    logic    pop;

    logic [NrOpQueue-1:0][VRegWidth-1:0] vs_sel;
    logic [NrOpQueue-1:0] req_act;
    logic [NrOpQueue-1:0] busy;
    logic [NrOpQueue-1:0] hs;
    logic [NrOpQueue-1:0] last;
    logic [NrOpQueue-1:0] complete;
    logic [NrOpQueue-1:0] q_ok;

    assign head           = fifo_q[rd_ptr_q];
    assign not_empty      = (count_q != 2'd0);
    // A full FIFO refuses pushes even when the head pops in the same cycle.
    assign op_req_ready_o = (count_q != 2'd2);
    assign push           = op_req_valid_i && op_req_ready_o;

    // ---- Stage boundary: head entry decode into per-queue access control ----
    always_comb begin
        vs_sel         = '0;
        req_act        = '0;
        busy           = '0;
        hs             = '0;
        last           = '0;
        complete       = '0;
        q_ok           = '0;
        rd_req_valid_o = '0;
        rd_req_addr_o  = '0;
        for (int q = 0; q < NrOpQueue; q++) begin
            vs_sel[q]  = (q == 0) ? head.vs1 : head.vs2;
            // Queue still owes work for the head entry.
            req_act[q] = not_empty && head.queue_req[q] && !fin_q[q];
            busy[q]    = req_act[q] && (head.acc_cnt != '0);
            hs[q]      = busy[q] && rd_req_ready_i[q];
            last[q]    = hs[q] && (cnt_q[q] == head.acc_cnt - CntOne);
            // A zero-count request completes on its first head cycle; the pop
            // happens in that same cycle, so this fires only once.
            complete[q] = last[q] || (req_act[q] && (head.acc_cnt == '0));
            q_ok[q]     = !head.queue_req[q] || fin_q[q] || complete[q];
            rd_req_valid_o[q] = busy[q];
            // Grouped registers run into the following registers; the sum
            // wraps naturally at the address width.
            if (busy[q]) begin
                rd_req_addr_o[q] = (AddrWidth'(vs_sel[q]) << LogBlocks)
                                 + AddrWidth'(cnt_q[q]);
            end
        end
        pop = not_empty && (&q_ok);
    end

    // ---- Stage boundary: FIFO payload write ----
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= op_req_t'(op_req_i);
        end
    end

    // ---- Stage boundary: control state and registered completion outputs ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q         <= 1'b0;
            wr_ptr_q         <= 1'b0;
            count_q          <= 2'd0;
            cnt_q            <= '0;
            fin_q            <= '0;
            op_access_done_o <= '0;
            op_access_vs_o   <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
            for (int q = 0; q < NrOpQueue; q++) begin
                if (pop) begin
                    fin_q[q] <= 1'b0;
                end else if (complete[q]) begin
                    fin_q[q] <= 1'b1;
                end
                if (last[q]) begin
                    cnt_q[q] <= '0;
                end else if (hs[q]) begin
                    cnt_q[q] <= cnt_q[q] + CntOne;
                end
                op_access_done_o[q] <= complete[q];
                op_access_vs_o[q]   <= complete[q] ? vs_sel[q] : '0;
            end
        end
    end

endmodule

// File: tb/tb_op_req_sequencer.sv
// Testbench for op_req_sequencer: cycle-exact vector table, hand-written
// multi-cycle sequences (FIFO full, reset mid-stream) and a randomized run
// checked against a transaction-level model of per-queue address streams.
module tb_op_req_sequencer;

    localparam int NQ   = 2;
    localparam int VW   = 5;
    localparam int BPV  = 4;
    localparam int CW   = 8;
    localparam int AW   = 7;
    localparam int NREQ = 60;

    logic clk = 1'b0;
    logic rst_n;
    logic op_req_valid;
    logic op_req_ready;
    logic [2*VW+NQ+CW-1:0] op_req;
    logic [NQ-1:0] rd_valid;
    logic [NQ-1:0][AW-1:0] rd_addr;
    logic [NQ-1:0] rd_ready;
    logic [NQ-1:0] done;
    logic [NQ-1:0][VW-1:0] done_vs;

    always #5 clk = ~clk;

    op_req_sequencer #(
        .NrOpQueue(NQ), .VRegWidth(VW), .BlocksPerVReg(BPV), .AccCntWidth(CW), .AddrWidth(AW)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .op_req_valid_i(op_req_valid),
        .op_req_ready_o(op_req_ready),
        .op_req_i(op_req),
        .rd_req_valid_o(rd_valid),
        .rd_req_addr_o(rd_addr),
        .rd_req_ready_i(rd_ready),
        .op_access_done_o(done),
        .op_access_vs_o(done_vs)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int v, vs1, vs2, qr, acc, rdy;
        int erdy, eval, ea0, ea1, edone, evs0, evs1;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int v, vs1, vs2, qr, acc, rdy,
                                erdy, eval, ea0, ea1, edone, evs0, evs1);
        vec_t r;
        r.v = v; r.vs1 = vs1; r.vs2 = vs2; r.qr = qr; r.acc = acc; r.rdy = rdy;
        r.erdy = erdy; r.eval = eval; r.ea0 = ea0; r.ea1 = ea1;
        r.edone = edone; r.evs0 = evs0; r.evs1 = evs1;
        return r;
    endfunction

    task automatic drive(input int v, input int vs1, input int vs2,
                         input int qr, input int acc, input int rdy);
        op_req_valid = 1'(v);
        op_req       = {5'(vs1), 5'(vs2), 2'(qr), 8'(acc)};
        rd_ready     = 2'(rdy);
    endtask

    // Called at posedge+1; samples at the negedge, returns at next posedge+1.
    task automatic apply_row(input vec_t r, input string tag);
        drive(r.v, r.vs1, r.vs2, r.qr, r.acc, r.rdy);
        @(negedge clk);
        check({tag, " op_req_ready"}, int'(op_req_ready), r.erdy);
        check({tag, " rd_valid"}, int'(rd_valid), r.eval);
        for (int q = 0; q < NQ; q++) begin
            if (((r.eval >> q) & 1) != 0)
                check($sformatf("%s addr%0d", tag, q), int'(rd_addr[q]), (q == 0) ? r.ea0 : r.ea1);
        end
        check({tag, " done"}, int'(done), r.edone);
        for (int q = 0; q < NQ; q++) begin
            if (((r.edone >> q) & 1) != 0)
                check($sformatf("%s vs%0d", tag, q), int'(done_vs[q]), (q == 0) ? r.evs0 : r.evs1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " op_req_ready"}, int'(op_req_ready), 1);
        check({tag, " rd_valid"}, int'(rd_valid), 0);
        check({tag, " addr0"}, int'(rd_addr[0]), 0);
        check({tag, " addr1"}, int'(rd_addr[1]), 0);
        check({tag, " done"}, int'(done), 0);
        check({tag, " vs0"}, int'(done_vs[0]), 0);
        check({tag, " vs1"}, int'(done_vs[1]), 0);
    endtask

    // Transaction-level reference: per queue, the ordered list of block
    // addresses still owed and the done pulses still owed (with how many
    // accesses must have been granted before each one).
    int  exp_addr     [NQ][$];
    int  exp_done_vs  [NQ][$];
    int  exp_done_cum [NQ][$];
    int  total_owed   [NQ];
    int  consumed     [NQ];
    bit  mon_en   = 1'b0;
    bit  acc_seen = 1'b0;
    int  cur_vs1, cur_vs2, cur_qr, cur_acc;

    always @(negedge clk) begin
        if (mon_en) begin
            for (int q = 0; q < NQ; q++) begin
                if (done[q]) begin
                    if (exp_done_vs[q].size() == 0) begin
                        check($sformatf("rnd q%0d unexpected done", q), 1, 0);
                    end else begin
                        check($sformatf("rnd q%0d done vs", q), int'(done_vs[q]), exp_done_vs[q].pop_front());
                        check($sformatf("rnd q%0d accesses before done", q), consumed[q], exp_done_cum[q].pop_front());
                    end
                end
            end
            for (int q = 0; q < NQ; q++) begin
                if (rd_valid[q]) begin
                    if (exp_addr[q].size() == 0) begin
                        check($sformatf("rnd q%0d spurious valid", q), 1, 0);
                    end else if (rd_ready[q]) begin
                        check($sformatf("rnd q%0d addr", q), int'(rd_addr[q]), exp_addr[q].pop_front());
                        consumed[q]++;
                    end
                end
            end
            if (op_req_valid && op_req_ready) begin
                for (int q = 0; q < NQ; q++) begin
                    if (((cur_qr >> q) & 1) != 0) begin
                        int vs;
                        vs = (q == 0) ? cur_vs1 : cur_vs2;
                        for (int k = 0; k < cur_acc; k++)
                            exp_addr[q].push_back((vs * BPV + k) % (1 << AW));
                        total_owed[q] += cur_acc;
                        exp_done_vs[q].push_back(vs);
                        exp_done_cum[q].push_back(total_owed[q]);
                    end
                end
                acc_seen = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int cyc;
        bit pending;
        bit drained;

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single request on q0.
        tbl.push_back(mk(1, 3, 0, 1, 4, 3,  1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3,  1, 1, 12, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3,  1, 1, 13, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3,  1, 1, 14, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3,  1, 1, 15, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3,  1, 0, 0, 0, 1, 3, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3,  1, 0, 0, 0, 0, 0, 0));
        // Both queues, q1 stalled for two cycles.
        tbl.push_back(mk(1, 2, 5, 3, 3, 3,  1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,  1, 3, 8, 20, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1,  1, 3, 9, 20, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3,  1, 3, 10, 20, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3,  1, 2, 0, 21, 1, 2, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3,  1, 2, 0, 22, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3,  1, 0, 0, 0, 2, 0, 5));
        // Zero access count on both queues.
        tbl.push_back(mk(1, 7, 9, 3, 0, 3,  1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3,  1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3,  1, 0, 0, 0, 3, 7, 9));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3,  1, 0, 0, 0, 0, 0, 0));
        // Address wrap past the top register.
        tbl.push_back(mk(1, 31, 0, 1, 6, 3, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3,  1, 1, 124, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3,  1, 1, 125, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3,  1, 1, 126, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3,  1, 1, 127, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3,  1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3,  1, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3,  1, 0, 0, 0, 1, 31, 0));
        // No queue requested: silent pop.
        tbl.push_back(mk(1, 10, 11, 0, 5, 3, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3,  1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3,  1, 0, 0, 0, 0, 0, 0));
        // Back-to-back requests, no bubble between entries.
        tbl.push_back(mk(1, 1, 0, 1, 2, 3,  1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 6, 0, 1, 2, 3,  1, 1, 4, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3,  0, 1, 5, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3,  1, 1, 24, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3,  1, 1, 25, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3,  1, 0, 0, 0, 1, 6, 0));

        for (int i = 0; i < tbl.size(); i++)
            apply_row(tbl[i], $sformatf("vec%0d", i));

        // FIFO full with grants withheld; third request waits for the first pop.
        apply_row(mk(1, 1, 0, 1, 2, 0, 1, 0, 0, 0, 0, 0, 0), "full c0");
        apply_row(mk(1, 2, 0, 1, 2, 0, 1, 1, 4, 0, 0, 0, 0), "full c1");
        apply_row(mk(1, 3, 0, 1, 2, 0, 0, 1, 4, 0, 0, 0, 0), "full c2");
        apply_row(mk(1, 3, 0, 1, 2, 0, 0, 1, 4, 0, 0, 0, 0), "full c3");
        apply_row(mk(1, 3, 0, 1, 2, 1, 0, 1, 4, 0, 0, 0, 0), "full c4");
        apply_row(mk(1, 3, 0, 1, 2, 1, 0, 1, 5, 0, 0, 0, 0), "full c5");
        apply_row(mk(1, 3, 0, 1, 2, 1, 1, 1, 8, 0, 1, 1, 0), "full c6");
        apply_row(mk(0, 0, 0, 0, 0, 1, 0, 1, 9, 0, 0, 0, 0), "full c7");
        apply_row(mk(0, 0, 0, 0, 0, 1, 1, 1, 12, 0, 1, 2, 0), "full c8");
        apply_row(mk(0, 0, 0, 0, 0, 1, 1, 1, 13, 0, 0, 0, 0), "full c9");
        apply_row(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 3, 0), "full c10");

        // Reset after two of four accesses.
        apply_row(mk(1, 4, 0, 1, 4, 3, 1, 0, 0, 0, 0, 0, 0), "rst c0");
        apply_row(mk(0, 0, 0, 0, 0, 3, 1, 1, 16, 0, 0, 0, 0), "rst c1");
        apply_row(mk(0, 0, 0, 0, 0, 3, 1, 1, 17, 0, 0, 0, 0), "rst c2");
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 3);
        #1;
        check_reset_state("midrst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        apply_row(mk(0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0), "post c0");
        apply_row(mk(0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0), "post c1");
        apply_row(mk(1, 4, 0, 1, 4, 3, 1, 0, 0, 0, 0, 0, 0), "re c0");
        apply_row(mk(0, 0, 0, 0, 0, 3, 1, 1, 16, 0, 0, 0, 0), "re c1");
        apply_row(mk(0, 0, 0, 0, 0, 3, 1, 1, 17, 0, 0, 0, 0), "re c2");
        apply_row(mk(0, 0, 0, 0, 0, 3, 1, 1, 18, 0, 0, 0, 0), "re c3");
        apply_row(mk(0, 0, 0, 0, 0, 3, 1, 1, 19, 0, 0, 0, 0), "re c4");
        apply_row(mk(0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1, 4, 0), "re c5");

        // Randomized traffic against the stream model.
        for (int q = 0; q < NQ; q++) begin
            total_owed[q] = 0;
            consumed[q]   = 0;
        end
        sent    = 0;
        pending = 1'b0;
        drained = 1'b0;
        mon_en  = 1'b1;
        for (cyc = 0; cyc < 4000 && !drained; cyc++) begin
            if (acc_seen) begin
                acc_seen = 1'b0;
                pending  = 1'b0;
                sent++;
            end
            if (!pending && sent < NREQ && $urandom_range(0, 3) != 0) begin
                cur_vs1 = $urandom_range(0, 31);
                cur_vs2 = $urandom_range(0, 31);
                cur_qr  = $urandom_range(0, 3);
                cur_acc = $urandom_range(0, 9);
                pending = 1'b1;
            end
            drive(pending ? 1 : 0, cur_vs1, cur_vs2, cur_qr, cur_acc,
                  (($urandom_range(0, 3) != 0) ? 1 : 0) | (($urandom_range(0, 3) != 0) ? 2 : 0));
            @(posedge clk);
            #1;
            drained = (sent == NREQ) && !pending && !acc_seen
                   && exp_addr[0].size() == 0 && exp_addr[1].size() == 0
                   && exp_done_vs[0].size() == 0 && exp_done_vs[1].size() == 0;
        end
        mon_en = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        check("rnd requests accepted", sent, NREQ);
        check("rnd q0 accesses owed", exp_addr[0].size(), 0);
        check("rnd q1 accesses owed", exp_addr[1].size(), 0);
        check("rnd q0 dones owed", exp_done_vs[0].size(), 0);
        check("rnd q1 dones owed", exp_done_vs[1].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
